// File: rtl/rptr_empty_ctrl_pkg.sv
// Shared FIFO definitions: default geometry and Gray/binary helpers used by
// both the read-side and write-side pointer controllers.
package rptr_empty_ctrl_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int AE_LEVEL_DEF = 2;

  // Helpers operate on 32-bit vectors; callers truncate to pointer width.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin_f(input logic [31:0] gray);
    logic [31:0] bin;
    bin = '0;
    for (int i = 0; i < 32; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/rptr_empty_ctrl_if.sv
// Read-side FIFO pointer bundle: requests and synchronized write pointer in,
// address, Gray pointer and status flags out.
interface rptr_empty_ctrl_if #(
  parameter int ADDRSIZE = 4
);
  logic                rinc_i;
  logic [ADDRSIZE:0]   rq2_wptr_i;
  logic [ADDRSIZE-1:0] raddr_o;
  logic [ADDRSIZE:0]   rptr_o;
  logic                rempty_o;
  logic                raempty_o;
  logic [ADDRSIZE:0]   rlevel_o;
  logic                runderflow_o;

  modport master (
    output rinc_i, rq2_wptr_i,
    input  raddr_o, rptr_o, rempty_o, raempty_o, rlevel_o, runderflow_o
  );

  modport slave (
    input  rinc_i, rq2_wptr_i,
    output raddr_o, rptr_o, rempty_o, raempty_o, rlevel_o, runderflow_o
  );
endinterface

// File: rtl/rptr_empty_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter of parameterized width.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < W; i++) begin
      bin_o[i] = ^(gray_i >> i);
    end
  end

endmodule

// File: rtl/rptr_empty_ctrl.sv
// Read-domain FIFO pointer controller: binary/Gray read pointer, registered
// empty/almost-empty flags, occupancy and a sticky underflow flag.
module rptr_empty_ctrl
  import rptr_empty_ctrl_pkg::*;
#(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int AE_LEVEL = AE_LEVEL_DEF
) (
  input  logic                  rclk_i,
  input  logic                  rrst_ni,
  rptr_empty_ctrl_if.slave      rif
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          runderflow_q, runderflow_d;

  logic          pop;
  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin_next;
  logic [PW-1:0] rgray_next;
  logic [PW-1:0] level_next;

  gray2bin #(.W(PW)) u_gray2bin (
    .gray_i (rif.rq2_wptr_i),
    .bin_o  (wbin)
  );

  // Flags are computed from the post-pop pointer so the last pop raises
  // empty on the same edge, and a simultaneous write is folded in too.
  always_comb begin
    pop          = rif.rinc_i & ~rempty_q;
    rbin_next    = rbin_q + {{ADDRSIZE{1'b0}}, pop};
    rgray_next   = PW'(bin2gray(32'(rbin_next)));
    level_next   = wbin - rbin_next;

    rbin_d       = rbin_next;
    rptr_d       = rgray_next;
    rlevel_d     = level_next;
    rempty_d     = (rgray_next == rif.rq2_wptr_i);
    raempty_d    = (level_next <= AE_THR);
    runderflow_d = runderflow_q | (rif.rinc_i & rempty_q);
  end

  always_ff @(posedge rclk_i) begin
    if (!rrst_ni) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rlevel_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rlevel_q     <= rlevel_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign rif.raddr_o      = rbin_q[ADDRSIZE-1:0];
  assign rif.rptr_o       = rptr_q;
  assign rif.rempty_o     = rempty_q;
  assign rif.raempty_o    = raempty_q;
  assign rif.rlevel_o     = rlevel_q;
  assign rif.runderflow_o = runderflow_q;

endmodule
